// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR owner turning controller strobes into a memory req/ack handshake.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYC cycles.
module lc3_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic              selMDR,
    input  logic              memWE,
    input  logic              enaMDR,
    output logic [DATA_W-1:0] mdr_bus,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              protocol_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(16'hDEAD);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d;
    logic              idle, rd_cmd, wr_cmd, ld_cmd, go_rd, go_wr, illegal, tmo;

    assign idle   = state_q == IDLE;
    assign rd_cmd = ldMDR & selMDR;
    assign ld_cmd = ldMDR & ~selMDR;
    assign wr_cmd = memWE;
    assign go_rd  = idle & rd_cmd & ~wr_cmd & ~ldMAR;
    assign go_wr  = idle & wr_cmd & ~rd_cmd & ~ld_cmd & ~ldMAR;
    // Outside IDLE any strobe is a controller bug; inside IDLE only conflicting combinations are.
    assign illegal = idle ? (rd_cmd & wr_cmd) | (ldMAR & (rd_cmd | wr_cmd)) | (ld_cmd & wr_cmd)
                          : ldMAR | ldMDR | memWE;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tmo   = cnt_q == CW'(TIMEOUT_CYC - 1);
    assign cnt_d = ((state_q == RD) || (state_q == WR)) && !mem_ack ? cnt_q + CW'(1) : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        err_d   = err_q | illegal;
        case (state_q)
            IDLE: begin
                if (ldMAR) mar_d = bus_in[ADDR_W-1:0];
                if (ld_cmd) mdr_d = bus_in;
                state_d = go_rd ? RD : go_wr ? WR : IDLE;
            end
            RD: begin
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = DONE;
                end else if (tmo) begin
                    mdr_d   = TMO_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WR: begin
                if (mem_ack) state_d = DONE;
                else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == RD) || (state_d == WR);
        we_d  = state_d == WR;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end

    assign mdr_bus      = enaMDR ? mdr_q : '0;
    assign mem_busy     = !idle || go_rd || go_wr;
    assign mem_done     = state_q == DONE;
    assign protocol_err = err_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = mar_q;
    assign mem_wdata    = mdr_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed self-checking bench for lc3_mem_ctrl.
module tb_lc3_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_in, mdr_bus, mem_addr, mem_wdata, mem_rdata;
    logic        ldMAR, ldMDR, selMDR, memWE, enaMDR;
    logic        mem_busy, mem_done, protocol_err, mem_req, mem_we, mem_ack;
    int          n_tests = 0;
    int          n_fail  = 0;

    lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .selMDR(selMDR), .memWE(memWE), .enaMDR(enaMDR), .mdr_bus(mdr_bus),
        .mem_busy(mem_busy), .mem_done(mem_done), .protocol_err(protocol_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cmds();
        ldMAR  = 1'b0;
        ldMDR  = 1'b0;
        selMDR = 1'b0;
        memWE  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; bus_in = '0; mem_rdata = '0; mem_ack = 1'b0; enaMDR = 1'b1;
        idle_cmds();
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_err", protocol_err, 0);
        chk("rst_mdr", mdr_bus, 0);
        chk("rst_done", mem_done, 0);
        #20 rst_n = 1'b1;
        step();
        // zero-wait read
        ldMAR = 1'b1; bus_in = 16'h3000;
        step();
        ldMAR = 1'b0;
        #1;
        chk("mar_load", mem_addr, 16'h3000);
        chk("mar_load_busy", mem_busy, 0);
        ldMDR = 1'b1; selMDR = 1'b1;
        #1;
        chk("rd_accept_busy", mem_busy, 1);
        chk("rd_accept_noreq", mem_req, 0);
        step();
        idle_cmds(); mem_ack = 1'b1; mem_rdata = 16'hABCD;
        #1;
        chk("rd_req", mem_req, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, 16'h3000);
        chk("rd_nodone", mem_done, 0);
        step();
        mem_ack = 1'b0;
        #1;
        chk("rd_done", mem_done, 1);
        chk("rd_done_noreq", mem_req, 0);
        chk("rd_done_busy", mem_busy, 1);
        chk("rd_mdr_bus", mdr_bus, 16'hABCD);
        enaMDR = 1'b0;
        #1;
        chk("rd_mdr_bus_off", mdr_bus, 0);
        enaMDR = 1'b1;
        step();
        chk("rd_idle_done", mem_done, 0);
        chk("rd_idle_busy", mem_busy, 0);
        chk("rd_no_err", protocol_err, 0);
        // write with 3 wait cycles
        ldMAR = 1'b1; bus_in = 16'h4001;
        step();
        ldMAR = 1'b0; ldMDR = 1'b1; selMDR = 1'b0; bus_in = 16'h1234;
        step();
        idle_cmds();
        #1;
        chk("wr_mdr_load", mem_wdata, 16'h1234);
        chk("wr_mdr_busy", mem_busy, 0);
        memWE = 1'b1;
        step();
        idle_cmds(); bus_in = '0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            chk($sformatf("wr_req%0d", i), mem_req, 1);
            chk($sformatf("wr_we%0d", i), mem_we, 1);
            chk($sformatf("wr_addr%0d", i), mem_addr, 16'h4001);
            chk($sformatf("wr_data%0d", i), mem_wdata, 16'h1234);
            step();
        end
        mem_ack = 1'b0;
        #1;
        chk("wr_done", mem_done, 1);
        chk("wr_done_noreq", mem_req, 0);
        step();
        chk("wr_idle_busy", mem_busy, 0);
        chk("wr_idle_done", mem_done, 0);
        // stray ack in IDLE
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_done", mem_done, 0);
        chk("idle_ack_busy", mem_busy, 0);
        // ldMAR while busy reading
        ldMDR = 1'b1; selMDR = 1'b1;
        step();
        idle_cmds(); ldMAR = 1'b1; bus_in = 16'h5555;
        step();
        ldMAR = 1'b0;
        #1;
        chk("coll_mar", mem_addr, 16'h4001);
        chk("coll_err", protocol_err, 1);
        chk("coll_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        step();
        mem_ack = 1'b0;
        #1;
        chk("coll_done", mem_done, 1);
        chk("coll_mdr", mdr_bus, 16'h0F0F);
        step();
        chk("coll_idle_busy", mem_busy, 0);
        // async reset in the middle of a read
        ldMDR = 1'b1; selMDR = 1'b1;
        step();
        idle_cmds(); mem_rdata = 16'h9999;
        #1;
        chk("mid_rd_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_busy", mem_busy, 0);
        chk("arst_mar", mem_addr, 0);
        chk("arst_mdr", mdr_bus, 0);
        chk("arst_err", protocol_err, 0);
        step();
        rst_n = 1'b1; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        chk("post_rst_req", mem_req, 0);
        chk("post_rst_busy", mem_busy, 0);
        chk("post_rst_mdr", mdr_bus, 0);
        // read-start and memWE together
        ldMDR = 1'b1; selMDR = 1'b1; memWE = 1'b1;
        #1;
        chk("rdwr_busy_now", mem_busy, 0);
        step();
        idle_cmds();
        #1;
        chk("rdwr_req", mem_req, 0);
        chk("rdwr_err", protocol_err, 1);
        chk("rdwr_busy", mem_busy, 0);
        // MDR load with memWE: load wins
        ldMDR = 1'b1; memWE = 1'b1; bus_in = 16'h7777;
        step();
        idle_cmds();
        #1;
        chk("ldwr_mdr", mdr_bus, 16'h7777);
        chk("ldwr_req", mem_req, 0);
        // MAR load with memWE: MAR load wins
        ldMAR = 1'b1; memWE = 1'b1; bus_in = 16'h6666;
        step();
        idle_cmds();
        #1;
        chk("marwr_mar", mem_addr, 16'h6666);
        chk("marwr_req", mem_req, 0);
        chk("marwr_busy", mem_busy, 0);
`ifdef MEM_TIMEOUT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        ldMDR = 1'b1; selMDR = 1'b1;
        step();
        idle_cmds();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("tmo_req%0d", i), mem_req, 1);
            step();
        end
        #1;
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_done", mem_done, 1);
        chk("tmo_mdr", mdr_bus, 16'hDEAD);
        chk("tmo_err", protocol_err, 1);
        step();
        chk("tmo_idle_busy", mem_busy, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory-access stage directly downstream of the LC-3 controller FSM.
- Owns the MAR and MDR registers and turns the controller's ldMAR / ldMDR / selMDR / enaMDR / memWE strobes into a req/ack handshake with external memory.
- Returns a busy/ready indication so the controller holds its fetch, load and store states until memory completes.
- Also drives MDR onto the shared bus when enabled.

Parameters:
- ADDR_W, 16, width of MAR and mem_addr.
- DATA_W, 16, width of MDR, bus and memory data.
- TIMEOUT_CYC, 255, cycles a request may wait for mem_ack before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus_in  input  DATA_W  shared datapath bus value.
- ldMAR  input  1  load MAR from bus_in[ADDR_W-1:0].
- ldMDR  input  1  load MDR; source chosen by selMDR.
- selMDR  input  1  1 = start memory read into MDR; 0 = load MDR from bus_in.
- memWE  input  1  start memory write of MDR to address MAR.
- enaMDR  input  1  drive MDR onto bus.
- mdr_bus  output  DATA_W  MDR when enaMDR=1, else 0.
- mem_busy  output  1  access in progress; controller must hold state.
- mem_done  output  1  one-cycle pulse when an access completes.
- protocol_err  output  1  sticky illegal-command flag.
- mem_req  output  1  request to memory, registered.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  ADDR_W  MAR, registered.
- mem_wdata  output  DATA_W  MDR, registered.
- mem_rdata  input  DATA_W  read data, valid with mem_ack.
- mem_ack  input  1  memory completion, sampled on clk.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, MAR, MDR, mem_req, mem_we, mem_busy, mem_done, protocol_err and timeout counter are 0; state = IDLE. Asserting reset mid-access aborts it: mem_req drops immediately, MDR is not updated.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - ldMAR=1 -> MAR <= bus_in at the edge.
  - ldMDR=1 with selMDR=0 -> MDR <= bus_in.
  - ldMDR=1 with selMDR=1 -> go to RD.
  - memWE=1 -> go to WR.
- RD: mem_req=1, mem_we=0, mem_addr=MAR. On an edge with mem_ack=1: MDR <= mem_rdata, go to DONE.
- WR: mem_req=1, mem_we=1, mem_wdata=MDR. On an edge with mem_ack=1: go to DONE.
- DONE: mem_done=1 and mem_req=0 for exactly one cycle, then IDLE.
- mem_busy=1 in RD, WR and DONE, and combinationally also in the IDLE cycle that accepts a start command.
- Minimum latency:
  - Command at edge N, mem_req high after edge N.
  - If ack is present in that same cycle, MDR is updated at edge N+1.
  - mem_done is high in cycle N+1..N+2; the FSM is back in IDLE after edge N+2.
- mem_ack outside RD/WR is ignored.
- mem_req stays asserted and address/data stay stable until ack.
- Illegal commands set protocol_err (cleared only by reset):
  - Any of ldMAR/ldMDR/memWE while not IDLE: command ignored.
  - Read-start and memWE in the same cycle: neither access starts.
  - ldMAR together with a read or write start: MAR load wins, no access starts.
- ldMDR(selMDR=0) together with memWE is also illegal: protocol_err set, MDR load wins, no write starts.
- mdr_bus is combinational from the MDR register and enaMDR.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to RD/WR and increments each cycle without ack.
  - When it reaches TIMEOUT_CYC, the FSM goes to DONE, mem_req drops and protocol_err is set.
  - A timed-out read leaves MDR = 16'hDEAD (DATA_W-truncated).
- MEM_TIMEOUT_EN undefined: no counter; the FSM waits for ack indefinitely.

Test Plan:
- Reset: rst_n low mid-read (mem_req=1) -> mem_req, mem_busy, MAR, MDR all 0 in the same cycle, without waiting for a clock edge; state IDLE after release.
- Read, zero wait: ldMAR with bus 16'h3000, then ldMDR+selMDR; memory acks in the first req cycle with 16'hABCD -> mem_addr=16'h3000, MDR=16'hABCD one edge later, a single mem_done pulse, and mdr_bus=16'hABCD when enaMDR=1.
- Write, 3 wait cycles: MAR=16'h4001, MDR loaded from bus 16'h1234, memWE; ack after 3 cycles -> mem_req=1, mem_we=1 for 4 cycles with stable addr/data, then mem_done, then mem_busy=0.
- Busy collision: ldMAR with bus 16'h5555 while in RD -> MAR unchanged, protocol_err=1; the read completes normally.
- Simultaneous ldMDR(selMDR=1)+memWE in IDLE -> no mem_req, protocol_err=1.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYC=4): read with no ack -> mem_req drops after 4 cycles, mem_done pulses, MDR=16'hDEAD, protocol_err=1.
